// File: rtl/id_stage_reg_pkg.sv
// Shared widths and the control-bundle layout for the ID/EXE pipeline register.
// Imported by id_stage_reg and its field registers.
package id_stage_reg_pkg;

  localparam int DEF_WORD_LEN        = 32;
  localparam int DEF_REG_ADDRESS_LEN = 4;
  localparam int EXE_CMD_LEN         = 4;
  localparam int SHIFTER_OPERAND_LEN = 12;
  localparam int SIGNED_IMM_LEN      = 24;
  localparam int STATUS_LEN          = 4;
  localparam int BUBBLE_CNT_LEN      = 16;

  typedef struct packed {
    logic                   wb_en;
    logic                   mem_read_en;
    logic                   mem_write_en;
    logic                   branch;
    logic                   status_update;
    logic                   imm;
    logic [EXE_CMD_LEN-1:0] exe_cmd;
    logic                   valid;
  } ctrl_t;

endpackage

// File: rtl/id_stage_reg_pipe_field_reg.sv
// pipe_field_reg: width-parameterised flop, sync active-low reset, hold, clear, load.
// Ports: clk, rst, i_hold, i_clr, i_d[W], o_q[W]. Priority: rst, hold, clr, load.
module pipe_field_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_hold,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst)
      r_q <= '0;
    else if (i_hold)
      r_q <= r_q;
    else if (i_clr)
      r_q <= '0;
    else
      r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/id_stage_reg.sv
// ID/EXE pipeline register: load, freeze hold, flush/hazard bubble insertion.
// Ports: clk, rst (sync, active-low), freeze, flush, hazard_detected, id_* in,
// exe_* out, exe_valid; bubble_count only when ID_STAGE_BUBBLE_COUNT_EN is defined.
module id_stage_reg
  import id_stage_reg_pkg::*;
#(
  parameter int WORD_LEN        = DEF_WORD_LEN,
  parameter int REG_ADDRESS_LEN = DEF_REG_ADDRESS_LEN
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           freeze,
  input  logic                           flush,
  input  logic                           hazard_detected,
  input  logic                           id_wb_en,
  input  logic                           id_mem_read_en,
  input  logic                           id_mem_write_en,
  input  logic                           id_branch,
  input  logic                           id_status_update,
  input  logic                           id_imm,
  input  logic [EXE_CMD_LEN-1:0]         id_exe_cmd,
  input  logic [WORD_LEN-1:0]            id_val_rn,
  input  logic [WORD_LEN-1:0]            id_val_rm,
  input  logic [WORD_LEN-1:0]            id_pc,
  input  logic [SHIFTER_OPERAND_LEN-1:0] id_shifter_operand,
  input  logic [SIGNED_IMM_LEN-1:0]      id_signed_imm,
  input  logic [STATUS_LEN-1:0]          id_status,
  input  logic [REG_ADDRESS_LEN-1:0]     id_dest,
  input  logic [REG_ADDRESS_LEN-1:0]     id_src1,
  input  logic [REG_ADDRESS_LEN-1:0]     id_src2,
  output logic                           exe_wb_en,
  output logic                           exe_mem_read_en,
  output logic                           exe_mem_write_en,
  output logic                           exe_branch,
  output logic                           exe_status_update,
  output logic                           exe_imm,
  output logic [EXE_CMD_LEN-1:0]         exe_exe_cmd,
  output logic [WORD_LEN-1:0]            exe_val_rn,
  output logic [WORD_LEN-1:0]            exe_val_rm,
  output logic [WORD_LEN-1:0]            exe_pc,
  output logic [SHIFTER_OPERAND_LEN-1:0] exe_shifter_operand,
  output logic [SIGNED_IMM_LEN-1:0]      exe_signed_imm,
  output logic [STATUS_LEN-1:0]          exe_status,
  output logic [REG_ADDRESS_LEN-1:0]     exe_dest,
  output logic [REG_ADDRESS_LEN-1:0]     exe_src1,
  output logic [REG_ADDRESS_LEN-1:0]     exe_src2,
`ifdef ID_STAGE_BUBBLE_COUNT_EN
  output logic [BUBBLE_CNT_LEN-1:0]      bubble_count,
`endif
  output logic                           exe_valid
);

  localparam int DATA_W = 3 * WORD_LEN;
  localparam int MISC_W =
    SHIFTER_OPERAND_LEN + SIGNED_IMM_LEN + STATUS_LEN;
  localparam int REGS_W = 3 * REG_ADDRESS_LEN;

  // Flush and hazard share one bubble; OR-ing them counts it once.
  logic w_bubble;
  assign w_bubble = flush | hazard_detected;

  ctrl_t w_ctrl_d;
  ctrl_t w_ctrl_q;

  always_comb begin
    w_ctrl_d               = '0;
    w_ctrl_d.wb_en         = id_wb_en;
    w_ctrl_d.mem_read_en   = id_mem_read_en;
    w_ctrl_d.mem_write_en  = id_mem_write_en;
    w_ctrl_d.branch        = id_branch;
    w_ctrl_d.status_update = id_status_update;
    w_ctrl_d.imm           = id_imm;
    w_ctrl_d.exe_cmd       = id_exe_cmd;
    w_ctrl_d.valid         = 1'b1;
  end

  logic [DATA_W-1:0] w_data_q;
  logic [MISC_W-1:0] w_misc_q;
  logic [REGS_W-1:0] w_regs_q;

  pipe_field_reg #(.W($bits(ctrl_t))) u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .i_hold (freeze),
    .i_clr  (w_bubble),
    .i_d    (w_ctrl_d),
    .o_q    (w_ctrl_q)
  );

  pipe_field_reg #(.W(DATA_W)) u_data (
    .clk    (clk),
    .rst    (rst),
    .i_hold (freeze),
    .i_clr  (w_bubble),
    .i_d    ({id_val_rn, id_val_rm, id_pc}),
    .o_q    (w_data_q)
  );

  pipe_field_reg #(.W(MISC_W)) u_misc (
    .clk    (clk),
    .rst    (rst),
    .i_hold (freeze),
    .i_clr  (w_bubble),
    .i_d    ({id_shifter_operand, id_signed_imm, id_status}),
    .o_q    (w_misc_q)
  );

  pipe_field_reg #(.W(REGS_W)) u_regs (
    .clk    (clk),
    .rst    (rst),
    .i_hold (freeze),
    .i_clr  (w_bubble),
    .i_d    ({id_dest, id_src1, id_src2}),
    .o_q    (w_regs_q)
  );

  assign exe_wb_en         = w_ctrl_q.wb_en;
  assign exe_mem_read_en   = w_ctrl_q.mem_read_en;
  assign exe_mem_write_en  = w_ctrl_q.mem_write_en;
  assign exe_branch        = w_ctrl_q.branch;
  assign exe_status_update = w_ctrl_q.status_update;
  assign exe_imm           = w_ctrl_q.imm;
  assign exe_exe_cmd       = w_ctrl_q.exe_cmd;
  assign exe_valid         = w_ctrl_q.valid;

  assign {exe_val_rn, exe_val_rm, exe_pc} = w_data_q;
  assign {exe_shifter_operand, exe_signed_imm, exe_status} = w_misc_q;
  assign {exe_dest, exe_src1, exe_src2} = w_regs_q;

`ifdef ID_STAGE_BUBBLE_COUNT_EN
  logic [BUBBLE_CNT_LEN-1:0] r_bubble_count;

  always_ff @(posedge clk) begin
    if (!rst)
      r_bubble_count <= '0;
    else if (!freeze && w_bubble && (r_bubble_count != '1))
      r_bubble_count <= r_bubble_count + 1'b1;
  end

  assign bubble_count = r_bubble_count;
`endif

endmodule

// File: tb/tb_id_stage_reg.sv
// Directed testbench for id_stage_reg: reset, load, hazard, freeze,
// flush, mid-stream reset, and (with ID_STAGE_BUBBLE_COUNT_EN) saturation.
module tb_id_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze, flush, hazard_detected;
  logic        id_wb_en, id_mem_read_en, id_mem_write_en;
  logic        id_branch, id_status_update, id_imm;
  logic [3:0]  id_exe_cmd;
  logic [31:0] id_val_rn, id_val_rm, id_pc;
  logic [11:0] id_shifter_operand;
  logic [23:0] id_signed_imm;
  logic [3:0]  id_status;
  logic [3:0]  id_dest, id_src1, id_src2;
  logic        exe_wb_en, exe_mem_read_en, exe_mem_write_en;
  logic        exe_branch, exe_status_update, exe_imm;
  logic [3:0]  exe_exe_cmd;
  logic [31:0] exe_val_rn, exe_val_rm, exe_pc;
  logic [11:0] exe_shifter_operand;
  logic [23:0] exe_signed_imm;
  logic [3:0]  exe_status;
  logic [3:0]  exe_dest, exe_src1, exe_src2;
  logic        exe_valid;
`ifdef ID_STAGE_BUBBLE_COUNT_EN
  logic [15:0] bubble_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_stage_reg dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .hazard_detected(hazard_detected),
    .id_wb_en(id_wb_en), .id_mem_read_en(id_mem_read_en),
    .id_mem_write_en(id_mem_write_en), .id_branch(id_branch),
    .id_status_update(id_status_update), .id_imm(id_imm),
    .id_exe_cmd(id_exe_cmd), .id_val_rn(id_val_rn),
    .id_val_rm(id_val_rm), .id_pc(id_pc),
    .id_shifter_operand(id_shifter_operand),
    .id_signed_imm(id_signed_imm), .id_status(id_status),
    .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2),
    .exe_wb_en(exe_wb_en), .exe_mem_read_en(exe_mem_read_en),
    .exe_mem_write_en(exe_mem_write_en), .exe_branch(exe_branch),
    .exe_status_update(exe_status_update), .exe_imm(exe_imm),
    .exe_exe_cmd(exe_exe_cmd), .exe_val_rn(exe_val_rn),
    .exe_val_rm(exe_val_rm), .exe_pc(exe_pc),
    .exe_shifter_operand(exe_shifter_operand),
    .exe_signed_imm(exe_signed_imm), .exe_status(exe_status),
    .exe_dest(exe_dest), .exe_src1(exe_src1), .exe_src2(exe_src2),
`ifdef ID_STAGE_BUBBLE_COUNT_EN
    .bubble_count(bubble_count),
`endif
    .exe_valid(exe_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ids(input logic v);
    id_wb_en = v; id_mem_read_en = v; id_mem_write_en = v;
    id_branch = v; id_status_update = v; id_imm = v;
    id_exe_cmd = {4{v}}; id_val_rn = {32{v}}; id_val_rm = {32{v}};
    id_pc = {32{v}}; id_shifter_operand = {12{v}};
    id_signed_imm = {24{v}}; id_status = {4{v}};
    id_dest = {4{v}}; id_src1 = {4{v}}; id_src2 = {4{v}};
  endtask

  task automatic test_reset();
    freeze = 0; flush = 0; hazard_detected = 0;
    set_ids(1'b1);
    rst = 0;
    tick(); tick();
    checks++; if (exe_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", exe_valid); end
    checks++; if (exe_wb_en !== 1'b0) begin errors++; $display("FAIL rst_wb_en got=%b exp=0", exe_wb_en); end
    checks++; if (exe_val_rn !== 32'h0) begin errors++; $display("FAIL rst_val_rn got=%h exp=0", exe_val_rn); end
    checks++; if ({exe_dest, exe_src1, exe_src2} !== 12'h0) begin errors++; $display("FAIL rst_regs got=%h exp=0", {exe_dest, exe_src1, exe_src2}); end
    checks++; if ({exe_shifter_operand, exe_signed_imm, exe_status, exe_exe_cmd} !== 44'h0) begin errors++; $display("FAIL rst_misc got=%h exp=0", {exe_shifter_operand, exe_signed_imm, exe_status}); end
`ifdef ID_STAGE_BUBBLE_COUNT_EN
    checks++; if (bubble_count !== 16'h0) begin errors++; $display("FAIL rst_bcount got=%h exp=0", bubble_count); end
`endif
  endtask

  task automatic test_load();
    set_ids(1'b0);
    rst = 1;
    id_dest = 4'h5; id_wb_en = 1; id_val_rn = 32'hDEADBEEF;
    id_pc = 32'h0000_0104; id_signed_imm = 24'hABCDEF; id_status = 4'h9;
    tick();
    checks++; if (exe_dest !== 4'h5) begin errors++; $display("FAIL load_dest got=%h exp=5", exe_dest); end
    checks++; if (exe_wb_en !== 1'b1) begin errors++; $display("FAIL load_wb_en got=%b exp=1", exe_wb_en); end
    checks++; if (exe_val_rn !== 32'hDEADBEEF) begin errors++; $display("FAIL load_val_rn got=%h exp=deadbeef", exe_val_rn); end
    checks++; if (exe_valid !== 1'b1) begin errors++; $display("FAIL load_valid got=%b exp=1", exe_valid); end
    checks++; if ({exe_pc, exe_signed_imm, exe_status} !== {32'h104, 24'hABCDEF, 4'h9}) begin errors++; $display("FAIL load_misc got=%h %h %h", exe_pc, exe_signed_imm, exe_status); end
  endtask

  task automatic test_hazard();
    set_ids(1'b0);
    id_mem_read_en = 1; id_wb_en = 1; id_dest = 4'h3;
    id_val_rm = 32'h1234_5678; id_exe_cmd = 4'hA;
    hazard_detected = 1;
    tick();
    checks++; if ({exe_valid, exe_mem_read_en, exe_wb_en} !== 3'b000) begin errors++; $display("FAIL haz1_ctrl got=%b exp=000", {exe_valid, exe_mem_read_en, exe_wb_en}); end
    checks++; if ({exe_dest, exe_val_rm} !== 36'h0) begin errors++; $display("FAIL haz1_data got=%h exp=0", {exe_dest, exe_val_rm}); end
`ifdef ID_STAGE_BUBBLE_COUNT_EN
    checks++; if (bubble_count !== 16'd1) begin errors++; $display("FAIL haz1_bcount got=%0d exp=1", bubble_count); end
`endif
    tick();
    checks++; if ({exe_valid, exe_mem_read_en} !== 2'b00) begin errors++; $display("FAIL haz2_ctrl got=%b exp=00", {exe_valid, exe_mem_read_en}); end
`ifdef ID_STAGE_BUBBLE_COUNT_EN
    checks++; if (bubble_count !== 16'd2) begin errors++; $display("FAIL haz2_bcount got=%0d exp=2", bubble_count); end
`endif
    hazard_detected = 0;
    tick();
    checks++; if ({exe_valid, exe_mem_read_en, exe_wb_en} !== 3'b111) begin errors++; $display("FAIL haz_rel_ctrl got=%b exp=111", {exe_valid, exe_mem_read_en, exe_wb_en}); end
    checks++; if ({exe_dest, exe_val_rm, exe_exe_cmd} !== {4'h3, 32'h1234_5678, 4'hA}) begin errors++; $display("FAIL haz_rel_data got=%h %h %h", exe_dest, exe_val_rm, exe_exe_cmd); end
  endtask

  task automatic test_freeze();
    freeze = 1; flush = 1; hazard_detected = 1;
    id_dest = 4'h7; id_val_rm = 32'h0; id_mem_read_en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({exe_valid, exe_mem_read_en, exe_dest} !== {2'b11, 4'h3}) begin errors++; $display("FAIL frz%0d_ctrl got=%b%b %h", i, exe_valid, exe_mem_read_en, exe_dest); end
      checks++; if (exe_val_rm !== 32'h1234_5678) begin errors++; $display("FAIL frz%0d_val_rm got=%h exp=12345678", i, exe_val_rm); end
`ifdef ID_STAGE_BUBBLE_COUNT_EN
      checks++; if (bubble_count !== 16'd2) begin errors++; $display("FAIL frz%0d_bcount got=%0d exp=2", i, bubble_count); end
`endif
    end
    freeze = 0; flush = 0; hazard_detected = 0;
  endtask

  task automatic test_flush_hazard();
    flush = 1; hazard_detected = 1;
    tick();
    checks++; if ({exe_valid, exe_wb_en, exe_dest} !== 6'h0) begin errors++; $display("FAIL fh_bubble got=%b%b %h exp=0", exe_valid, exe_wb_en, exe_dest); end
`ifdef ID_STAGE_BUBBLE_COUNT_EN
    checks++; if (bubble_count !== 16'd3) begin errors++; $display("FAIL fh_bcount got=%0d exp=3", bubble_count); end
`endif
    flush = 0; hazard_detected = 0;
    tick();
    checks++; if ({exe_valid, exe_dest} !== {1'b1, 4'h7}) begin errors++; $display("FAIL fh_reload got=%b %h exp=1 7", exe_valid, exe_dest); end
    flush = 1;
    tick();
    checks++; if ({exe_valid, exe_dest} !== 5'h0) begin errors++; $display("FAIL flush_bubble got=%b %h exp=0", exe_valid, exe_dest); end
`ifdef ID_STAGE_BUBBLE_COUNT_EN
    checks++; if (bubble_count !== 16'd4) begin errors++; $display("FAIL flush_bcount got=%0d exp=4", bubble_count); end
`endif
    flush = 0;
  endtask

  task automatic test_reset_midstream();
    tick();
    checks++; if ({exe_valid, exe_dest} !== {1'b1, 4'h7}) begin errors++; $display("FAIL mid_load got=%b %h exp=1 7", exe_valid, exe_dest); end
    rst = 0; freeze = 1;
    tick();
    checks++; if ({exe_valid, exe_wb_en, exe_dest} !== 6'h0) begin errors++; $display("FAIL mid_rst got=%b%b %h exp=0", exe_valid, exe_wb_en, exe_dest); end
`ifdef ID_STAGE_BUBBLE_COUNT_EN
    checks++; if (bubble_count !== 16'd0) begin errors++; $display("FAIL mid_rst_bcount got=%0d exp=0", bubble_count); end
`endif
    rst = 1; freeze = 0; hazard_detected = 1;
    tick();
    checks++; if (exe_valid !== 1'b0) begin errors++; $display("FAIL mid_bubble got=%b exp=0", exe_valid); end
`ifdef ID_STAGE_BUBBLE_COUNT_EN
    checks++; if (bubble_count !== 16'd1) begin errors++; $display("FAIL mid_bcount got=%0d exp=1", bubble_count); end
`endif
    hazard_detected = 0;
    tick();
    checks++; if ({exe_valid, exe_dest} !== {1'b1, 4'h7}) begin errors++; $display("FAIL mid_reload got=%b %h exp=1 7", exe_valid, exe_dest); end
  endtask

`ifdef ID_STAGE_BUBBLE_COUNT_EN
  task automatic test_saturation();
    rst = 0;
    tick();
    rst = 1; hazard_detected = 1;
    repeat (65534) tick();
    checks++; if (bubble_count !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got=%h exp=fffe", bubble_count); end
    repeat (3) tick();
    checks++; if (bubble_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffff", bubble_count); end
    checks++; if (exe_valid !== 1'b0) begin errors++; $display("FAIL sat_valid got=%b exp=0", exe_valid); end
    hazard_detected = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_hazard();
    test_freeze();
    test_flush_hazard();
    test_reset_midstream();
`ifdef ID_STAGE_BUBBLE_COUNT_EN
    test_saturation();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
